// File: rtl/fifo2ram_pkg.sv
// Shared definitions for the FIFO/RAM burst movers: FSM state encoding and
// default bus widths.
package fifo2ram_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRead = 2'd1,
    StDone = 2'd2
  } state_e;

  localparam int unsigned DefDw = 8;
  localparam int unsigned DefAw = 12;
  localparam int unsigned DefLw = 12;

endpackage

// File: rtl/fifo2ram_if.sv
// Controller handshake, FIFO read port and RAM write port of the fifo2ram mover.
// The master modport is the mover itself; slave is its environment.
interface fifo2ram_if #(
  parameter int unsigned DW = fifo2ram_pkg::DefDw,
  parameter int unsigned AW = fifo2ram_pkg::DefAw,
  parameter int unsigned LW = fifo2ram_pkg::DefLw
) ();

  logic          fs;
  logic          fd;
  logic          busy;
  logic [AW-1:0] addr_base;
  logic [LW-1:0] len;
  logic [DW-1:0] fifo_rxd;
  logic          fifo_empty;
  logic          fifo_rxen;
  logic          ram_txen;
  logic [AW-1:0] ram_txa;
  logic [DW-1:0] ram_txd;

  modport master (
    input  fs,
    input  addr_base,
    input  len,
    input  fifo_rxd,
    input  fifo_empty,
    output fd,
    output busy,
    output fifo_rxen,
    output ram_txen,
    output ram_txa,
    output ram_txd
  );

  modport slave (
    output fs,
    output addr_base,
    output len,
    output fifo_rxd,
    output fifo_empty,
    input  fd,
    input  busy,
    input  fifo_rxen,
    input  ram_txen,
    input  ram_txa,
    input  ram_txd
  );

endinterface

// File: rtl/fifo2ram.sv
// Copies a burst of len words from a latency-1 FIFO into a RAM write port,
// starting at addr_base, and reports completion on fd.
module fifo2ram
  import fifo2ram_pkg::*;
#(
  parameter int unsigned DW = DefDw,
  parameter int unsigned AW = DefAw,
  parameter int unsigned LW = DefLw
) (
  input  logic       clk,
  input  logic       rst,
  fifo2ram_if.master bus
);

  state_e        state;
  logic [AW-1:0] base_q;
  logic [LW-1:0] len_q;
  logic [LW-1:0] rd_cnt_q;
  logic [LW-1:0] wr_cnt_q;
  logic          rxen_q;
  logic          fd_q;
  logic          busy_q;
  logic          rd_more;
  logic          last_wr;

  assign rd_more = (rd_cnt_q < len_q);
  assign last_wr = rxen_q && (wr_cnt_q == len_q - LW'(1));

  assign bus.fifo_rxen = (state == StRead) && !bus.fifo_empty && rd_more;
  // FIFO data arrives one cycle after the read, in step with rxen_q.
  assign bus.ram_txen  = rxen_q;
  assign bus.ram_txa   = base_q + AW'(wr_cnt_q);
  assign bus.ram_txd   = rxen_q ? bus.fifo_rxd : DW'(0);
  assign bus.fd        = fd_q;
  assign bus.busy      = busy_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= StIdle;
      base_q   <= '0;
      len_q    <= '0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
      rxen_q   <= 1'b0;
      fd_q     <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      rxen_q <= bus.fifo_rxen;
      unique case (state)
        StIdle: begin
          if (bus.fs) begin
            base_q   <= bus.addr_base;
            len_q    <= bus.len;
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
            if (bus.len != '0) begin
              state  <= StRead;
              busy_q <= 1'b1;
            end else begin
              state <= StDone;
              fd_q  <= 1'b1;
            end
          end
        end
        StRead: begin
          if (bus.fifo_rxen) begin
            rd_cnt_q <= rd_cnt_q + LW'(1);
          end
          if (rxen_q) begin
            wr_cnt_q <= wr_cnt_q + LW'(1);
          end
          if (last_wr) begin
            state  <= StDone;
            busy_q <= 1'b0;
            fd_q   <= 1'b1;
          end
        end
        StDone: begin
          // Hold fd until the controller withdraws its request.
          if (!bus.fs) begin
            state <= StIdle;
            fd_q  <= 1'b0;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/fifo2ram.md
# fifo2ram

Drains a fixed-length burst of words from a standard-mode (read-latency-1) FIFO into a simple-dual-port RAM write port, starting at a caller-supplied base address. It is the write-side counterpart of the existing RAM-to-FIFO mover: a controller raises `fs`, the block copies `len` words, then answers with `fd`. It sits between a packet/ADC FIFO and the frame buffer RAM in the 200 MHz domain.

## Interface
- `DW`, 8: data width.
- `AW`, 12: RAM address width.
- `LW`, 12: transfer-length width.

- `clk` in 1: sole clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `fs` in 1: start request, level; held until `fd` seen.
- `fd` out 1: transfer finished, level.
- `busy` out 1: high from accept to `fd`.
- `addr_base` in AW: first RAM address, sampled on accept.
- `len` in LW: number of words, sampled on accept; 0 is legal.
- `fifo_rxd` in DW: FIFO read data, valid the cycle after `fifo_rxen`.
- `fifo_empty` in 1: FIFO empty flag.
- `fifo_rxen` out 1: FIFO read enable.
- `ram_txen` out 1: RAM write enable.
- `ram_txa` out AW: RAM write address.
- `ram_txd` out DW: RAM write data.

## Operation
- States: IDLE, READ, DONE.
- IDLE: when `fs`=1, latch `addr_base`→`base_r`, `len`→`len_r`, clear `rd_cnt`/`wr_cnt`; go READ if `len`≠0, else DONE.
- READ: `fifo_rxen` = !`fifo_empty` && (`rd_cnt` < `len_r`), combinational from registered state; `rd_cnt` increments per issued read.
- Write stage: `ram_txen` = `fifo_rxen` delayed one cycle; `ram_txd` = `fifo_rxd` in that cycle; `ram_txa` = `base_r` + `wr_cnt` mod 2^AW (wraps silently); `wr_cnt` increments per write.
- READ→DONE on the cycle the write with `wr_cnt` = `len_r`−1 occurs.
- DONE: `fd`=1, `busy`=0; return to IDLE when `fs`=0. If `fs` already low on entry, `fd` is high exactly one cycle.
- `fs` dropping mid-transfer is ignored; the burst completes.
- `fs` still high in IDLE immediately after DONE cannot happen (DONE waits for `fs`=0).
- FIFO empty mid-burst: reads stall, no write issued for the stalled slot, addresses stay contiguous.
- Never reads more than `len_r` words; never reads when `fifo_empty`=1.

## Timing
- Reset (`rst`=0, async): state IDLE; `fd`, `busy`, `fifo_rxen`, `ram_txen` = 0; `ram_txa`, `ram_txd`, counters = 0. Any in-flight read is dropped, no write follows it.
- Accept at edge 0 (`fs` sampled high in IDLE): `busy`=1 from cycle 1; first `fifo_rxen` cycle 1; first write cycle 2.
- FIFO never empty: writes on cycles 2..`len`+1, one per cycle; `fd`=1 from cycle `len`+2.
- `len`=0: `fd`=1 at cycle 1, no FIFO read, no RAM write.
- Each empty-stall cycle adds one cycle to total latency.

## Structure
- `fifo2ram_pkg`: state encoding localparams (IDLE, READ, DONE) shared with the RAM-to-FIFO mover's state constants.
- No sub-module; single FSM plus two counters and a one-stage write pipeline register (`rxen_d`).

## Test plan
- Reset, then `fs`, `addr_base`=0x010, `len`=4, FIFO preloaded 0xA1..0xA4 -> writes 0xA1..0xA4 to 0x010..0x013 on cycles 2..5, `fd`=1 cycle 6.
- `len`=0 -> `fd`=1 at cycle 1, `fifo_rxen` and `ram_txen` never assert.
- `addr_base`=0xFFE, `len`=4 -> addresses 0xFFE, 0xFFF, 0x000, 0x001.
- FIFO empty for 3 cycles after 2nd word, `len`=5 -> exactly 5 reads/writes, contiguous addresses, `fd` 3 cycles later than unstalled.
- `fs` dropped after cycle 2 with `len`=3 -> burst completes, `fd` high one cycle; FIFO holding 8 words leaves 5 unread.
- `rst` low at cycle 3 of an 8-word burst -> all outputs 0 immediately, no further `ram_txen`; new `fs` after release restarts cleanly.
